// File: rtl/fp_div_seq.sv
// Sequencer around an iterative IEEE-754 single-precision divider core.
// Special operands are resolved locally; normal operands are issued to the core with a done mask and a timeout.
module fp_div_seq #(
    parameter int MASK_CYC = 1,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        invalid,
    output logic        div_zero,
    output logic        timeout,
    output logic        div_start,
    output logic [31:0] div_op_a,
    output logic [31:0] div_op_b,
    input  logic        div_done,
    input  logic [31:0] div_res
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          div_start_q;
    logic [31:0]   res_q;
    logic          invalid_q;
    logic          div_zero_q;
    logic          timeout_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   op_a_q;
    logic [31:0]   op_b_q;

    logic          spec_s;
    logic [31:0]   spec_res_s;
    logic          spec_inv_s;
    logic          spec_dz_s;
    logic          sign_s;

    // Denormals are flushed: any zero exponent is treated as zero.
    function automatic logic is_zero(input logic [31:0] f);
        return f[30:23] == 8'd0;
    endfunction

    function automatic logic is_inf(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
    endfunction

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    // Classify the offered operands and form the special-case result in priority order.
    always_comb begin
        spec_s     = 1'b1;
        spec_res_s = 32'd0;
        spec_inv_s = 1'b0;
        spec_dz_s  = 1'b0;
        sign_s     = op_a[31] ^ op_b[31];
        if (is_nan(op_a) || is_nan(op_b) ||
            (is_zero(op_a) && is_zero(op_b)) ||
            (is_inf(op_a) && is_inf(op_b))) begin
            spec_res_s = QNAN;
            spec_inv_s = 1'b1;
        end else if (is_zero(op_b)) begin
            spec_res_s = {sign_s, 31'h7F80_0000};
            spec_dz_s  = 1'b1;
        end else if (is_inf(op_a)) begin
            spec_res_s = {sign_s, 31'h7F80_0000};
        end else if (is_zero(op_a) || is_inf(op_b)) begin
            spec_res_s = {sign_s, 31'd0};
        end else begin
            spec_s = 1'b0;
        end
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            div_start_q <= 1'b0;
            res_q       <= 32'd0;
            invalid_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            op_a_q      <= 32'd0;
            op_b_q      <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_a_q     <= op_a;
                        op_b_q     <= op_b;
                        in_ready_q <= 1'b0;
                        if (spec_s) begin
                            res_q       <= spec_res_s;
                            invalid_q   <= spec_inv_s;
                            div_zero_q  <= spec_dz_s;
                            timeout_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    div_start_q <= 1'b0;
                    cnt_q       <= {CW{1'b0}};
                    state_q     <= WAIT;
                end
                WAIT: begin
                    // A qualified done takes precedence over an expiring timeout.
                    if (div_done && (cnt_q >= CW'(MASK_CYC))) begin
                        res_q       <= div_res;
                        invalid_q   <= 1'b0;
                        div_zero_q  <= 1'b0;
                        timeout_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
                        res_q       <= QNAN;
                        invalid_q   <= 1'b1;
                        div_zero_q  <= 1'b0;
                        timeout_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    div_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign div_start = div_start_q;
    assign res       = res_q;
    assign invalid   = invalid_q;
    assign div_zero  = div_zero_q;
    assign timeout   = timeout_q;
    assign div_op_a  = op_a_q;
    assign div_op_b  = op_b_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq with a behavioural divider-core model driving div_done/div_res.
module tb_fp_div_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        invalid;
    logic        div_zero;
    logic        timeout;
    logic        div_start;
    logic [31:0] div_op_a;
    logic [31:0] div_op_b;
    logic        div_done;
    logic [31:0] div_res;

    int          n_vec;
    int          n_err;
    int          start_cnt;
    int          since;
    bit          active;
    bit          force_done;
    bit          core_never;
    int          core_delay;
    logic [31:0] core_res;
    logic        core_done;

    fp_div_seq #(.MASK_CYC(1), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .invalid(invalid), .div_zero(div_zero), .timeout(timeout),
        .div_start(div_start), .div_op_a(div_op_a), .div_op_b(div_op_b),
        .div_done(div_done), .div_res(div_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: done level rises core_delay cycles after the start cycle; it ignores rst_n on purpose.
    always @(posedge clk) begin
        if (div_start) begin
            active <= 1'b1;
            since  <= 0;
            start_cnt <= start_cnt + 1;
        end else if (active) begin
            since <= since + 1;
        end
    end

    assign core_done = active && !core_never && (since >= core_delay - 1);
    assign div_done  = core_done | force_done;
    assign div_res   = core_done ? core_res : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < max) begin
            @(negedge clk);
            cyc++;
            if (out_valid) ok = 1'b1;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
    endtask

    logic [31:0] sa [9];
    logic [31:0] sb [9];
    logic [31:0] sr [9];
    logic [2:0]  sf [9];

    initial begin
        int  cyc;
        int  base;
        bit  ok;
        bit  stable;
        bit  seen;
        n_vec = 0; n_err = 0; start_cnt = 0; since = 0; active = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; op_a = 32'd0; op_b = 32'd0; out_ready = 1'b0;
        force_done = 1'b0; core_never = 1'b0; core_delay = 57; core_res = 32'h4040_0000;

        // {a, b, res, {invalid,div_zero,timeout}}
        sa[0] = 32'h0000_0000; sb[0] = 32'h8000_0000; sr[0] = 32'h7FC0_0000; sf[0] = 3'b100;
        sa[1] = 32'hBF80_0000; sb[1] = 32'h7F80_0000; sr[1] = 32'h8000_0000; sf[1] = 3'b000;
        sa[2] = 32'h7FC0_0001; sb[2] = 32'h3F80_0000; sr[2] = 32'h7FC0_0000; sf[2] = 3'b100;
        sa[3] = 32'h7F80_0000; sb[3] = 32'hFF80_0000; sr[3] = 32'h7FC0_0000; sf[3] = 3'b100;
        sa[4] = 32'h7F80_0000; sb[4] = 32'h4000_0000; sr[4] = 32'h7F80_0000; sf[4] = 3'b000;
        sa[5] = 32'hFF80_0000; sb[5] = 32'h4000_0000; sr[5] = 32'hFF80_0000; sf[5] = 3'b000;
        sa[6] = 32'h0000_0001; sb[6] = 32'h3F80_0000; sr[6] = 32'h0000_0000; sf[6] = 3'b000;
        sa[7] = 32'h3F80_0000; sb[7] = 32'h8000_0001; sr[7] = 32'hFF80_0000; sf[7] = 3'b010;
        sa[8] = 32'h7F80_0000; sb[8] = 32'h0000_0000; sr[8] = 32'h7F80_0000; sf[8] = 3'b010;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_flags", 32'({invalid, div_zero, timeout}), 32'd0);
        chk("rst_div_op_a", div_op_a, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Normal divide 6/2, core answers 57 cycles after start.
        base = start_cnt;
        send(32'h40C0_0000, 32'h4000_0000);
        chk("norm_issue_start", 32'(div_start), 32'd1);
        chk("norm_in_ready", 32'(in_ready), 32'd0);
        wait_valid(200, cyc, ok);
        chk("norm_done_seen", 32'(ok), 32'd1);
        chk("norm_div_op_a", div_op_a, 32'h40C0_0000);
        chk("norm_div_op_b", div_op_b, 32'h4000_0000);
        chk("norm_res", res, 32'h4040_0000);
        chk("norm_flags", 32'({invalid, div_zero, timeout}), 32'd0);
        chk("norm_start_pulses", 32'(start_cnt - base), 32'd1);
        release_out();

        // Divide by zero: one-cycle latency, no start, held stable while out_ready low.
        base = start_cnt;
        send(32'h3F80_0000, 32'h0000_0000);
        chk("dz_out_valid", 32'(out_valid), 32'd1);
        chk("dz_res", res, 32'h7F80_0000);
        chk("dz_flags", 32'({invalid, div_zero, timeout}), 32'b010);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res !== 32'h7F80_0000 || {invalid, div_zero, timeout} !== 3'b010 ||
                out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        chk("dz_hold_stable", 32'(stable), 32'd1);
        chk("dz_no_start", 32'(start_cnt - base), 32'd0);
        release_out();

        for (int i = 0; i < 9; i++) begin
            send(sa[i], sb[i]);
            chk($sformatf("spec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("spec%0d_res", i), res, sr[i]);
            chk($sformatf("spec%0d_flags", i), 32'({invalid, div_zero, timeout}), 32'(sf[i]));
            release_out();
        end

        // Done held high through the masked first WAIT cycle must not be taken.
        core_delay = 10; core_res = 32'h3F00_0000; force_done = 1'b1;
        send(32'h3F80_0000, 32'h4000_0000);
        @(negedge clk);
        @(negedge clk);
        force_done = 1'b0;
        chk("mask_ignored", 32'(out_valid), 32'd0);
        wait_valid(100, cyc, ok);
        chk("mask_done_seen", 32'(ok), 32'd1);
        chk("mask_res", res, 32'h3F00_0000);
        chk("mask_flags", 32'({invalid, div_zero, timeout}), 32'd0);
        release_out();

        // Core never completes: 64 WAIT cycles then timeout result.
        core_never = 1'b1;
        send(32'h3F80_0000, 32'h4000_0000);
        wait_valid(200, cyc, ok);
        chk("to_seen", 32'(ok), 32'd1);
        chk("to_latency", 32'(cyc), 32'd65);
        chk("to_res", res, 32'h7FC0_0000);
        chk("to_flags", 32'({invalid, div_zero, timeout}), 32'b101);
        release_out();
        core_never = 1'b0;

        // Reset mid-WAIT; the core's later done must not produce an output.
        core_delay = 20;
        send(32'h40C0_0000, 32'h4000_0000);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_res", res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("stale_done_ignored", 32'(seen), 32'd0);
        chk("stale_in_ready", 32'(in_ready), 32'd1);

        core_delay = 5; core_res = 32'h4000_0000;
        send(32'h4080_0000, 32'h4000_0000);
        wait_valid(100, cyc, ok);
        chk("recover_seen", 32'(ok), 32'd1);
        chk("recover_res", res, 32'h4000_0000);
        release_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
